// File: rtl/regfile_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// regfile_wb_arbiter: round-robin write-back arbiter for the register file
// write port (A = ALU result, B = load result). Rev 1.0
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int CNT_W  = 16
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_hold,
  input  logic              i_aValid,
  input  logic [ADDR_W-1:0] i_aAdd,
  input  logic [DATA_W-1:0] i_aData,
  output logic              o_aReady,
  input  logic              i_bValid,
  input  logic [ADDR_W-1:0] i_bAdd,
  input  logic [DATA_W-1:0] i_bData,
  output logic              o_bReady,
  output logic              o_writeEn,
  output logic [ADDR_W-1:0] o_writeAdd,
  output logic [DATA_W-1:0] o_writeData,
  output logic              o_pendValid,
  output logic [ADDR_W-1:0] o_pendAdd,
  output logic [CNT_W-1:0]  o_writeCount
);

  typedef enum logic [0:0] {
    PRI_A = 1'b0,
    PRI_B = 1'b1
  } pri_e;

  pri_e              state_q, state_d;
  logic              write_en_q, write_en_d;
  logic [ADDR_W-1:0] write_add_q, write_add_d;
  logic [DATA_W-1:0] write_data_q, write_data_d;
  logic [CNT_W-1:0]  write_cnt_q, write_cnt_d;
  logic              grant_a, grant_b;

  always_comb begin
    grant_a      = 1'b0;
    grant_b      = 1'b0;
    state_d      = state_q;
    write_en_d   = 1'b0;
    write_add_d  = write_add_q;
    write_data_d = write_data_q;
    write_cnt_d  = write_cnt_q + {{(CNT_W-1){1'b0}}, write_en_q};

    // Readys are forced low while reset is held so nothing is accepted.
    if (i_rst_n && !i_hold) begin
      if (i_aValid && (!i_bValid || state_q == PRI_A)) begin
        grant_a = 1'b1;
      end else if (i_bValid) begin
        grant_b = 1'b1;
      end
    end

    if (grant_a) begin
      state_d      = PRI_B;
      write_en_d   = (i_aAdd != '0);
      write_add_d  = i_aAdd;
      write_data_d = i_aData;
    end else if (grant_b) begin
      state_d      = PRI_A;
      write_en_d   = (i_bAdd != '0);
      write_add_d  = i_bAdd;
      write_data_d = i_bData;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= PRI_A;
      write_en_q   <= 1'b0;
      write_add_q  <= '0;
      write_data_q <= '0;
      write_cnt_q  <= '0;
    end else begin
      state_q      <= state_d;
      write_en_q   <= write_en_d;
      write_add_q  <= write_add_d;
      write_data_q <= write_data_d;
      write_cnt_q  <= write_cnt_d;
    end
  end

  assign o_aReady     = grant_a;
  assign o_bReady     = grant_b;
  assign o_writeEn    = write_en_q;
  assign o_writeAdd   = write_add_q;
  assign o_writeData  = write_data_q;
  assign o_pendValid  = write_en_q;
  assign o_pendAdd    = write_add_q;
  assign o_writeCount = write_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_regfile_wb_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_regfile_wb_arbiter: directed self-checking bench for regfile_wb_arbiter.
// Rev 1.0
// ---------------------------------------------------------------------------
module tb_regfile_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        hold;
  logic        a_valid;
  logic [4:0]  a_add;
  logic [31:0] a_data;
  logic        a_ready;
  logic        b_valid;
  logic [4:0]  b_add;
  logic [31:0] b_data;
  logic        b_ready;
  logic        wr_en;
  logic [4:0]  wr_add;
  logic [31:0] wr_data;
  logic        pend_valid;
  logic [4:0]  pend_add;
  logic [15:0] wr_cnt;

  int errors = 0;
  int checks = 0;

  regfile_wb_arbiter #(
    .DATA_W(32),
    .ADDR_W(5),
    .CNT_W (16)
  ) dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_hold      (hold),
    .i_aValid    (a_valid),
    .i_aAdd      (a_add),
    .i_aData     (a_data),
    .o_aReady    (a_ready),
    .i_bValid    (b_valid),
    .i_bAdd      (b_add),
    .i_bData     (b_data),
    .o_bReady    (b_ready),
    .o_writeEn   (wr_en),
    .o_writeAdd  (wr_add),
    .o_writeData (wr_data),
    .o_pendValid (pend_valid),
    .o_pendAdd   (pend_add),
    .o_writeCount(wr_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  // Advance one clock; inputs are then driven 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; hold = 1'b0;
    a_valid = 1'b1; a_add = 5'd3; a_data = 32'h11;
    b_valid = 1'b1; b_add = 5'd4; b_data = 32'h22;

    // Reset with both requesters valid
    #1;
    chk("rst_aready", a_ready, 0);
    chk("rst_bready", b_ready, 0);
    chk("rst_wen",    wr_en,   0);
    chk("rst_wadd",   wr_add,  0);
    chk("rst_wdata",  wr_data, 0);
    chk("rst_cnt",    wr_cnt,  0);
    step();
    chk("rst_hold_aready", a_ready, 0);
    a_valid = 1'b0; b_valid = 1'b0;
    rst_n = 1'b1;
    step();

    // A only
    a_valid = 1'b1; a_add = 5'd5; a_data = 32'hDEADBEEF;
    #1;
    chk("aonly_aready", a_ready, 1);
    chk("aonly_bready", b_ready, 0);
    step();
    a_valid = 1'b0;
    chk("aonly_wen",   wr_en,      1);
    chk("aonly_wadd",  wr_add,     5);
    chk("aonly_wdata", wr_data,    32'hDEADBEEF);
    chk("aonly_pv",    pend_valid, 1);
    chk("aonly_padd",  pend_add,   5);
    chk("aonly_cnt0",  wr_cnt,     0);
    step();
    chk("aonly_cnt1",  wr_cnt, 1);
    chk("idle_wen",    wr_en,  0);
    chk("idle_wadd",   wr_add, 5);

    // Both valid from reset: grants A,B,A,B
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    a_valid = 1'b1; a_add = 5'd1; a_data = 32'd1;
    b_valid = 1'b1; b_add = 5'd9; b_data = 32'd9;
    #1;
    chk("rr1_aready", a_ready, 1);
    chk("rr1_bready", b_ready, 0);
    step();
    a_add = 5'd2; a_data = 32'd2;
    chk("rr2_bready", b_ready, 1);
    chk("rr2_aready", a_ready, 0);
    chk("rr2_wadd",   wr_add,  1);
    step();
    b_add = 5'd10; b_data = 32'd10;
    chk("rr3_aready", a_ready, 1);
    chk("rr3_wadd",   wr_add,  9);
    step();
    a_add = 5'd3; a_data = 32'd3;
    chk("rr4_bready", b_ready, 1);
    chk("rr4_wadd",   wr_add,  2);
    step();
    a_valid = 1'b0; b_valid = 1'b0;
    chk("rr5_wadd",  wr_add,  10);
    chk("rr5_wdata", wr_data, 10);
    step();
    chk("rr_cnt4", wr_cnt, 4);

    // B write to r0: accepted, suppressed
    b_valid = 1'b1; b_add = 5'd0; b_data = 32'h1234;
    #1;
    chk("r0_bready", b_ready, 1);
    step();
    b_valid = 1'b0;
    chk("r0_wen",  wr_en,  0);
    chk("r0_wadd", wr_add, 0);
    step();
    chk("r0_cnt", wr_cnt, 4);

    // Tie after the B grant goes to A
    a_valid = 1'b1; a_add = 5'd7; a_data = 32'h77;
    b_valid = 1'b1; b_add = 5'd8; b_data = 32'h88;
    #1;
    chk("tie_aready", a_ready, 1);
    chk("tie_bready", b_ready, 0);
    step();

    // Hold for three cycles with both valid
    hold = 1'b1; a_add = 5'd13; a_data = 32'hDD;
    #1;
    chk("hold1_wen",    wr_en,   1);
    chk("hold1_wadd",   wr_add,  7);
    chk("hold1_aready", a_ready, 0);
    chk("hold1_bready", b_ready, 0);
    step();
    chk("hold2_wen",    wr_en,   0);
    chk("hold2_aready", a_ready, 0);
    chk("hold2_bready", b_ready, 0);
    step();
    chk("hold3_wen",    wr_en,   0);
    chk("hold3_bready", b_ready, 0);
    step();
    hold = 1'b0;
    #1;
    chk("unhold_bready", b_ready, 1);
    chk("unhold_aready", a_ready, 0);
    step();
    b_valid = 1'b0;
    chk("unhold_wadd",  wr_add,  8);
    chk("unhold_wdata", wr_data, 32'h88);
    step();
    a_valid = 1'b0;
    step();
    chk("hold_cnt", wr_cnt, 7);

    // Reset mid-operation discards the staged write
    a_valid = 1'b1; a_add = 5'd3; a_data = 32'h33;
    step();
    a_valid = 1'b0;
    chk("mid_wen_pre", wr_en, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_wen_rst", wr_en,  0);
    chk("mid_cnt_rst", wr_cnt, 0);
    step();
    rst_n = 1'b1;

    // Counter wrap: 65535 writes then one more
    a_valid = 1'b1; a_add = 5'd1; a_data = 32'h5;
    repeat (65535) step();
    a_valid = 1'b0;
    step();
    chk("wrap_ffff", wr_cnt, 16'hFFFF);
    a_valid = 1'b1;
    step();
    a_valid = 1'b0;
    chk("wrap_wen", wr_en, 1);
    step();
    chk("wrap_zero", wr_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
